cmd_response_encoder: RTL

CMD_RESPONSE_ENCODER -- requirements
Module: cmd_response_encoder

---
 rtl/cmd_response_encoder_pkg.sv | 46 ++++
 rtl/cmd_response_encoder_if.sv | 28 ++
 rtl/cmd_response_encoder_nibble_to_ascii.sv | 12 +
 rtl/cmd_response_encoder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cmd_response_encoder_pkg.sv
// rtl/cmd_response_encoder_pkg.sv - shared command codes, tag table and encoder state encoding
package cmd_response_encoder_pkg;

  localparam int MAX_BYTES_DEFAULT = 5;
  localparam int TAG_LEN           = 10;

  typedef enum logic [2:0] {
    CMD_PB_I_WRITE = 3'd0,
    CMD_PB_I_READ  = 3'd1,
    CMD_PB_ADC4_16 = 3'd2,
    CMD_PB_ADC4_08 = 3'd3,
    CMD_TEST       = 3'd4,
    CMD_FAIL       = 3'd5,
    CMD_UNKNOWN_6  = 3'd6,
    CMD_UNKNOWN_7  = 3'd7
  } cmd_code_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TAG    = 3'd1;
  localparam logic [2:0] S_COMMA  = 3'd2;
  localparam logic [2:0] S_HEX_HI = 3'd3;
  localparam logic [2:0] S_HEX_LO = 3'd4;
  localparam logic [2:0] S_CR     = 3'd5;
  localparam logic [2:0] S_LF     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  function automatic logic [8*TAG_LEN-1:0] tag_string(input logic [2:0] code);
    case (cmd_code_e'(code))
      CMD_PB_I_WRITE: tag_string = "pb_i_write";
      CMD_PB_I_READ:  tag_string = "pb_i__read";
      CMD_PB_ADC4_16: tag_string = "pb_adc4_16";
      CMD_PB_ADC4_08: tag_string = "pb_adc4_08";
      CMD_TEST:       tag_string = "test______";
      CMD_FAIL:       tag_string = "fail______";
      default:        tag_string = "unknown___";
    endcase
  endfunction

  // Character 0 of the tag sits in the most significant byte of the string literal.
  function automatic logic [7:0] tag_char(input logic [2:0] code, input logic [3:0] idx);
    logic [8*TAG_LEN-1:0] s;
    s = tag_string(code) << {idx, 3'b000};
    tag_char = s[8*TAG_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/cmd_response_encoder_if.sv
// rtl/cmd_response_encoder_if.sv - request and TX FIFO signals of the response encoder
interface cmd_response_encoder_if
  import cmd_response_encoder_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) ();

  logic                   start;
  logic [2:0]             cmd_code;
  logic [2:0]             byte_count;
  logic [8*MAX_BYTES-1:0] payload;
  logic                   tx_fifo_full;
  logic [7:0]             tx_fifo_data_in;
  logic                   tx_fifo_write_en;
  logic                   busy;
  logic                   done;

  modport master (
    output start, cmd_code, byte_count, payload, tx_fifo_full,
    input  tx_fifo_data_in, tx_fifo_write_en, busy, done
  );

  modport slave (
    input  start, cmd_code, byte_count, payload, tx_fifo_full,
    output tx_fifo_data_in, tx_fifo_write_en, busy, done
  );

endinterface

// File: rtl/cmd_response_encoder_nibble_to_ascii.sv
// rtl/cmd_response_encoder_nibble_to_ascii.sv - 4-bit value to uppercase ASCII hex digit
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/cmd_response_encoder.sv
// rtl/cmd_response_encoder.sv - emits "<tag>,<hex payload>\r\n" sentences into a UART TX FIFO
module cmd_response_encoder
  import cmd_response_encoder_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  cmd_response_encoder_if.slave  bus
);

  localparam logic [2:0] MAX_N = 3'(MAX_BYTES);

  logic [2:0]             state;
  logic [3:0]             tag_idx;
  logic [2:0]             byte_idx;
  logic [2:0]             nbytes;
  logic [2:0]             cmd_r;
  logic [8*MAX_BYTES-1:0] payload_r;
  logic [7:0]             data_q;
  logic [2:0]             clamped;
  logic [7:0]             cur_byte;
  logic [3:0]             nibble;
  logic [7:0]             hex_char;
  logic [7:0]             char_now;
  logic                   emitting;
  logic                   write_en;

  always_comb begin
    clamped = (bus.byte_count > MAX_N) ? MAX_N : bus.byte_count;
    cur_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byte_idx == 3'(i)) cur_byte = payload_r[8*(MAX_BYTES-1-i) +: 8];
    end
    nibble = (state == S_HEX_HI) ? cur_byte[7:4] : cur_byte[3:0];
  end

  nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    case (state)
      S_TAG:              char_now = tag_char(cmd_r, tag_idx);
      S_COMMA:            char_now = 8'h2C;
      S_HEX_HI, S_HEX_LO: char_now = hex_char;
      S_CR:               char_now = 8'h0D;
      S_LF:               char_now = 8'h0A;
      default:            char_now = data_q;
    endcase
  end

  // Gating with reset_n keeps a reset edge from also committing a character.
  assign emitting             = (state != S_IDLE) && (state != S_DONE);
  assign write_en             = reset_n && emitting && !bus.tx_fifo_full;
  assign bus.tx_fifo_write_en = write_en;
  assign bus.tx_fifo_data_in  = write_en ? char_now : data_q;
  assign bus.busy             = emitting;
  assign bus.done             = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tag_idx   <= 4'd0;
      byte_idx  <= 3'd0;
      nbytes    <= 3'd0;
      cmd_r     <= 3'd0;
      payload_r <= '0;
      data_q    <= 8'h00;
    end else begin
      if (write_en) data_q <= char_now;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_TAG;
            tag_idx   <= 4'd0;
            byte_idx  <= 3'd0;
            nbytes    <= clamped;
            cmd_r     <= bus.cmd_code;
            payload_r <= bus.payload;
          end
        end
        S_TAG: begin
          if (write_en) begin
            if (tag_idx == 4'(TAG_LEN - 1)) begin
              state   <= S_COMMA;
              tag_idx <= 4'd0;
            end else begin
              tag_idx <= tag_idx + 4'd1;
            end
          end
        end
        S_COMMA: begin
          if (write_en) begin
            state    <= (nbytes != 3'd0) ? S_HEX_HI : S_CR;
            byte_idx <= 3'd0;
          end
        end
        S_HEX_HI: begin
          if (write_en) state <= S_HEX_LO;
        end
        S_HEX_LO: begin
          if (write_en) begin
            if (byte_idx == nbytes - 3'd1) begin
              state    <= S_CR;
              byte_idx <= 3'd0;
            end else begin
              state    <= S_HEX_HI;
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        S_CR: begin
          if (write_en) state <= S_LF;
        end
        S_LF: begin
          if (write_en) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
